// File: rtl/ysyx_040066_axi_bridge.sv
// AXI4 master bridge: serialises icache reads, dcache reads and dcache writes onto a single
// AXI4 port with one transaction outstanding at a time.
module ysyx_040066_axi_bridge #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  // icache read port
  input  logic                         ins_req,
  input  logic                         ins_burst,
  input  logic [63:0]                  ins_addr,
  output logic                         ins_ready,
  output logic                         ins_last,
  output logic                         ins_err,
  output logic [DATA_W-1:0]            ins_data,
  // dcache read port
  input  logic                         rd_req,
  input  logic                         rd_burst,
  input  logic [2:0]                   rd_len,
  input  logic [63:0]                  rd_addr,
  output logic                         rd_ready,
  output logic                         rd_last,
  output logic                         rd_err,
  output logic [DATA_W-1:0]            rd_data,
  // dcache write port
  input  logic                         wr_req,
  input  logic                         wr_burst,
  input  logic [2:0]                   wr_len,
  input  logic [DATA_W/8-1:0]          wr_mask,
  input  logic [63:0]                  wr_addr,
  input  logic [DATA_W*LINE_BEATS-1:0] wr_data,
  output logic                         wr_ready,
  output logic                         wr_err,
  // AR channel
  output logic                         axi_ar_valid,
  input  logic                         axi_ar_ready,
  output logic [ADDR_W-1:0]            axi_ar_addr,
  output logic [7:0]                   axi_ar_len,
  output logic [2:0]                   axi_ar_size,
  output logic [1:0]                   axi_ar_burst,
  // R channel
  input  logic                         axi_r_valid,
  output logic                         axi_r_ready,
  input  logic [DATA_W-1:0]            axi_r_data,
  input  logic [1:0]                   axi_r_resp,
  input  logic                         axi_r_last,
  // AW channel
  output logic                         axi_aw_valid,
  input  logic                         axi_aw_ready,
  output logic [ADDR_W-1:0]            axi_aw_addr,
  output logic [7:0]                   axi_aw_len,
  output logic [2:0]                   axi_aw_size,
  output logic [1:0]                   axi_aw_burst,
  // W channel
  output logic                         axi_w_valid,
  input  logic                         axi_w_ready,
  output logic [DATA_W-1:0]            axi_w_data,
  output logic [DATA_W/8-1:0]          axi_w_strb,
  output logic                         axi_w_last,
  // B channel
  input  logic                         axi_b_valid,
  output logic                         axi_b_ready,
  input  logic [1:0]                   axi_b_resp
);

  localparam int unsigned CntW     = $clog2(LINE_BEATS);
  localparam int unsigned OffW     = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned LineW    = DATA_W * LINE_BEATS;
  localparam logic [7:0]  BurstLen = 8'(LINE_BEATS - 1);
  localparam logic [2:0]  FullSize = 3'($clog2(StrbW));
  localparam logic [1:0]  BurstIncr = 2'b01;

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIns, OwnRd, OwnWr} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                rr_q, rr_d;          // 1: rd was the last read granted
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;        // sticky read error across beats
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [StrbW-1:0]    strb_q, strb_d;
  logic [LineW-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                beat_vld_q, beat_vld_d;
  logic                beat_last_q, beat_last_d;
  logic                beat_err_q, beat_err_d;
  logic                wr_done_q, wr_done_d;
  logic                wr_err_q, wr_err_d;
  logic                w_last;
  logic                grant_ok;
  logic                unused_addr_hi;

  // Only the low ADDR_W request address bits reach the bus.
  assign unused_addr_hi = ^{ins_addr[63:ADDR_W], rd_addr[63:ADDR_W], wr_addr[63:ADDR_W]};

  function automatic logic [ADDR_W-1:0] line_addr(input logic [63:0] a);
    return {a[ADDR_W-1:OffW], {OffW{1'b0}}};
  endfunction

  assign w_last = (state_q == StW) && (len_q == 8'(cnt_q));
  // Hold off arbitration while a completion strobe is visible: the requester still holds req.
  assign grant_ok = !beat_last_q && !wr_done_q;

  // Next-state: arbitration, request decode and per-channel sequencing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    beat_vld_d  = 1'b0;
    beat_last_d = 1'b0;
    beat_err_d  = 1'b0;
    wr_done_d   = 1'b0;
    wr_err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          if (wr_req) begin
            owner_d = OwnWr;
            state_d = StAw;
            cnt_d   = '0;
            addr_d  = wr_burst ? line_addr(wr_addr) : wr_addr[ADDR_W-1:0];
            len_d   = wr_burst ? BurstLen : 8'd0;
            size_d  = wr_burst ? FullSize : wr_len;
            strb_d  = wr_burst ? {StrbW{1'b1}} : wr_mask;
            wdata_d = wr_data;
          end else if (rd_req && (!ins_req || !rr_q)) begin
            owner_d = OwnRd;
            rr_d    = 1'b1;
            state_d = StAr;
            err_d   = 1'b0;
            addr_d  = rd_burst ? line_addr(rd_addr) : rd_addr[ADDR_W-1:0];
            len_d   = rd_burst ? BurstLen : 8'd0;
            size_d  = rd_burst ? FullSize : rd_len;
          end else if (ins_req) begin
            owner_d = OwnIns;
            rr_d    = 1'b0;
            state_d = StAr;
            err_d   = 1'b0;
            addr_d  = ins_burst ? line_addr(ins_addr) : ins_addr[ADDR_W-1:0];
            len_d   = ins_burst ? BurstLen : 8'd0;
            size_d  = FullSize;
          end
        end
      end
      StAr: begin
        if (axi_ar_ready) state_d = StR;
      end
      StR: begin
        // Completion follows r_last regardless of how many beats arrived.
        if (axi_r_valid) begin
          beat_vld_d = 1'b1;
          rdata_d    = axi_r_data;
          err_d      = err_q | (axi_r_resp != 2'b00);
          if (axi_r_last) begin
            beat_last_d = 1'b1;
            beat_err_d  = err_q | (axi_r_resp != 2'b00);
            state_d     = StIdle;
          end
        end
      end
      StAw: begin
        if (axi_aw_ready) begin
          state_d = StW;
          cnt_d   = '0;
        end
      end
      StW: begin
        if (axi_w_ready) begin
          if (w_last) state_d = StB;
          else        cnt_d   = cnt_q + 1'b1;
        end
      end
      StB: begin
        if (axi_b_valid) begin
          wr_done_d = 1'b1;
          wr_err_d  = axi_b_resp != 2'b00;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      beat_vld_q  <= 1'b0;
      beat_last_q <= 1'b0;
      beat_err_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      beat_vld_q  <= beat_vld_d;
      beat_last_q <= beat_last_d;
      beat_err_q  <= beat_err_d;
      wr_done_q   <= wr_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Bus-side outputs: valids/readies are decoded straight from the state.
  always_comb begin
    axi_ar_valid = state_q == StAr;
    axi_ar_addr  = addr_q;
    axi_ar_len   = len_q;
    axi_ar_size  = size_q;
    axi_ar_burst = BurstIncr;
    axi_r_ready  = state_q == StR;
    axi_aw_valid = state_q == StAw;
    axi_aw_addr  = addr_q;
    axi_aw_len   = len_q;
    axi_aw_size  = size_q;
    axi_aw_burst = BurstIncr;
    axi_w_valid  = state_q == StW;
    axi_w_data   = wdata_q[cnt_q*DATA_W +: DATA_W];
    axi_w_strb   = strb_q;
    axi_w_last   = w_last;
    axi_b_ready  = state_q == StB;
  end

  // Cache-side outputs: only the owner of the current transaction sees anything.
  always_comb begin
    ins_ready = beat_vld_q && (owner_q == OwnIns);
    ins_last  = beat_last_q && (owner_q == OwnIns);
    ins_err   = beat_err_q && (owner_q == OwnIns);
    ins_data  = ins_ready ? rdata_q : '0;
    rd_ready  = beat_vld_q && (owner_q == OwnRd);
    rd_last   = beat_last_q && (owner_q == OwnRd);
    rd_err    = beat_err_q && (owner_q == OwnRd);
    rd_data   = rd_ready ? rdata_q : '0;
    wr_ready  = wr_done_q && (owner_q == OwnWr);
    wr_err    = wr_err_q && (owner_q == OwnWr);
  end

endmodule
